// File: rtl/chaos_map_engine.sv
// Chaotic-map keystream datapath: tent50, logistic and tent runs in Q0.12 with done pulses.
// Optional seed guard (CHAOS_SEED_GUARD_EN) remaps degenerate seeds 0x000/0x800 to 0x5A5.
module chaos_map_engine #(
   parameter int DATA_WIDTH = 12,
   parameter int ITER_T50   = 16,
   parameter int ITER_LOG   = 8,
   parameter int ITER_T     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flag1,
   input  logic                  flag2,
   input  logic [1:0]            order,
   input  logic [DATA_WIDTH-1:0] key_in,
   input  logic [DATA_WIDTH-1:0] key2,
   input  logic [DATA_WIDTH-1:0] tent,
   output logic [DATA_WIDTH-1:0] k,
   output logic [DATA_WIDTH-1:0] logistic_key_out,
   output logic                  done1,
   output logic                  done2,
   output logic                  done3,
   output logic                  busy
);

   localparam logic [DATA_WIDTH-1:0] HALF = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] MAXV = '1;

   typedef enum logic [2:0] {
      IDLE, T50, WAIT_ORD, LOG1, WAIT_F2, TENT, LOG2, HOLD
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] x;
   logic [7:0]            cnt;
   logic [DATA_WIDTH-1:0] tent_x;
   logic [DATA_WIDTH-1:0] logi_x;
   logic [7:0]            log_len;

   function automatic logic [DATA_WIDTH-1:0] tent_map(input logic [DATA_WIDTH-1:0] v);
      logic [DATA_WIDTH-1:0] r;
      r = (v < HALF) ? v : (MAXV - v);
      return {r[DATA_WIDTH-2:0], 1'b0};
   endfunction

   // The product never exceeds 2^22, so bits [21:10] hold the whole scaled result.
   function automatic logic [DATA_WIDTH-1:0] logi_map(input logic [DATA_WIDTH-1:0] v);
      logic [2*DATA_WIDTH-1:0] p;
      p = {{DATA_WIDTH{1'b0}}, v} * {{DATA_WIDTH{1'b0}}, MAXV - v};
      return p[2*DATA_WIDTH-3:DATA_WIDTH-2];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] seed(input logic [DATA_WIDTH-1:0] v);
`ifdef CHAOS_SEED_GUARD_EN
      return (v == '0 || v == HALF) ? DATA_WIDTH'(12'h5A5) : v;
`else
      return v;
`endif
   endfunction

   assign tent_x  = tent_map(x);
   assign logi_x  = logi_map(x);
   assign log_len = 8'({6'd0, order} * 8'(ITER_LOG));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= IDLE;
         x                <= '0;
         cnt              <= '0;
         k                <= '0;
         logistic_key_out <= '0;
         done1            <= 1'b0;
         done2            <= 1'b0;
         done3            <= 1'b0;
         busy             <= 1'b0;
      end else begin
         done1 <= 1'b0;
         done2 <= 1'b0;
         done3 <= 1'b0;
         case (state)
            IDLE: if (flag1) begin
               x     <= seed(key_in);
               cnt   <= 8'(ITER_T50);
               state <= T50;
               busy  <= 1'b1;
            end
            T50: begin
               x   <= tent_x;
               cnt <= cnt - 8'd1;
               if (cnt == 8'd1) begin
                  k     <= tent_x;
                  done1 <= 1'b1;
                  state <= WAIT_ORD;
                  busy  <= 1'b0;
               end
            end
            WAIT_ORD: if (order != 2'd0) begin
               x     <= seed(key2);
               cnt   <= log_len;
               state <= LOG1;
               busy  <= 1'b1;
            end
            LOG1, LOG2: begin
               x   <= logi_x;
               cnt <= cnt - 8'd1;
               if (cnt == 8'd1) begin
                  logistic_key_out <= logi_x;
                  done2            <= 1'b1;
                  state            <= (state == LOG1) ? WAIT_F2 : HOLD;
                  busy             <= 1'b0;
               end
            end
            WAIT_F2: if (flag2) begin
               x     <= seed(tent);
               cnt   <= 8'(ITER_T);
               state <= TENT;
               busy  <= 1'b1;
            end
            TENT: begin
               x   <= tent_x;
               cnt <= cnt - 8'd1;
               // Hand straight to the final logistic round; busy stays high across it.
               if (cnt == 8'd1) begin
                  done3 <= 1'b1;
                  x     <= seed(tent_x);
                  cnt   <= log_len;
                  state <= LOG2;
               end
            end
            HOLD: if (!flag1 && !flag2) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chaos_map_engine.sv
// Bench for chaos_map_engine: short-iteration instance driven from a vector table,
// plus a default-parameter instance for the full session and mid-run reset.
module tb_chaos_map_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst_n, a_flag1, a_flag2;
   logic [1:0]  a_order;
   logic [11:0] a_key_in, a_key2, a_tent, a_k, a_lko;
   logic        a_done1, a_done2, a_done3, a_busy;

   logic        b_rst_n, b_flag1, b_flag2;
   logic [1:0]  b_order;
   logic [11:0] b_key_in, b_key2, b_tent, b_k, b_lko;
   logic        b_done1, b_done2, b_done3, b_busy;

   chaos_map_engine #(.DATA_WIDTH(12), .ITER_T50(1), .ITER_LOG(1), .ITER_T(1)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .flag1(a_flag1), .flag2(a_flag2), .order(a_order),
      .key_in(a_key_in), .key2(a_key2), .tent(a_tent), .k(a_k), .logistic_key_out(a_lko),
      .done1(a_done1), .done2(a_done2), .done3(a_done3), .busy(a_busy)
   );

   chaos_map_engine dut_b (
      .clk(clk), .rst_n(b_rst_n), .flag1(b_flag1), .flag2(b_flag2), .order(b_order),
      .key_in(b_key_in), .key2(b_key2), .tent(b_tent), .k(b_k), .logistic_key_out(b_lko),
      .done1(b_done1), .done2(b_done2), .done3(b_done3), .busy(b_busy)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [11:0] key_in;
      logic [11:0] key2;
      logic [1:0]  order;
      logic [11:0] tent;
      logic [11:0] exp_k;
      logic [11:0] exp_l1;
      logic [11:0] exp_l2;
   } vec_t;

   vec_t vt[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic pulse(input int sel);
      case (sel)
         0: return a_done1;
         1: return a_done2;
         2: return a_done3;
         3: return b_done1;
         4: return b_done2;
         default: return b_done3;
      endcase
   endfunction

   // Returns the number of ticks until the pulse is seen, or -1 on timeout.
   task automatic wait_pulse(input int sel, input int maxc, output int n);
      n = -1;
      for (int c = 1; c <= maxc; c++) begin
         tick();
         if (pulse(sel)) begin
            n = c;
            break;
         end
      end
   endtask

   // Reference arithmetic for the long default-parameter session.
   function automatic logic [11:0] m_tent(input logic [11:0] v);
      int t;
      t = (int'(v) < 2048) ? 2 * int'(v) : 2 * (4095 - int'(v));
      return 12'(t % 4096);
   endfunction

   function automatic logic [11:0] m_logi(input logic [11:0] v);
      int p;
      p = int'(v) * (4095 - int'(v));
      return 12'(p / 1024);
   endfunction

   function automatic logic [11:0] m_seed(input logic [11:0] v);
`ifdef CHAOS_SEED_GUARD_EN
      if (v == 12'h000 || v == 12'h800) return 12'h5A5;
`endif
      return v;
   endfunction

   logic mon_en = 1'b0;
   int   busy_cnt = 0;
   int   overlap = 0;
   int   seq[$];

   always @(negedge clk) begin
      if (mon_en) begin
         if (b_busy) busy_cnt++;
         if (b_busy && (b_done1 || b_done2)) overlap++;
         if (b_done1) seq.push_back(1);
         if (b_done2) seq.push_back(2);
         if (b_done3) seq.push_back(3);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int code;
      logic [11:0] mk, ml1, mt, ml2;

      vt[0] = '{12'h400, 12'h800, 2'd1, 12'hFFE, 12'h800, 12'hFFE, 12'h007};
`ifdef CHAOS_SEED_GUARD_EN
      vt[0].exp_l1 = 12'hE9B;
`endif
      vt[1] = '{12'h123, 12'h400, 2'd3, 12'h300, 12'h246, 12'hBFF, 12'hB81};
      vt[2] = '{12'h000, 12'h400, 2'd1, 12'h100, 12'h000, 12'hBFF, 12'h6FF};
`ifdef CHAOS_SEED_GUARD_EN
      vt[2].exp_k = 12'hB4A;
`endif
      vt[3] = '{12'hC00, 12'h200, 2'd2, 12'hA00, 12'h7FE, 12'hFBD, 12'hBFD};

      a_rst_n = 0; a_flag1 = 0; a_flag2 = 0; a_order = 0;
      a_key_in = 0; a_key2 = 0; a_tent = 0;
      b_rst_n = 0; b_flag1 = 0; b_flag2 = 0; b_order = 0;
      b_key_in = 0; b_key2 = 0; b_tent = 0;
      tick(); tick();

      check("rst_k", a_k, 0);
      check("rst_lko", a_lko, 0);
      check("rst_done", {a_done1, a_done2, a_done3}, 0);
      check("rst_busy", a_busy, 0);
      check("rst_b_k", b_k, 0);
      check("rst_b_busy", b_busy, 0);

      // Short-iteration instance: one vector per full session.
      for (int i = 0; i < 4; i++) begin
         a_rst_n = 0; a_flag1 = 0; a_flag2 = 0; a_order = 0;
         tick(); tick();
         a_rst_n = 1;
         a_key_in = vt[i].key_in;
         a_flag1 = 1;
         wait_pulse(0, 10, n);
         check($sformatf("v%0d_lat_done1", i), n, 2);
         check($sformatf("v%0d_k", i), a_k, vt[i].exp_k);
         check($sformatf("v%0d_busy_wait", i), a_busy, 0);
         a_flag1 = 0;
         tick();
         check($sformatf("v%0d_done1_width", i), a_done1, 0);
         a_key2 = vt[i].key2;
         a_order = vt[i].order;
         wait_pulse(1, 20, n);
         check($sformatf("v%0d_lat_done2a", i), n, int'(vt[i].order) + 1);
         check($sformatf("v%0d_lko1", i), a_lko, vt[i].exp_l1);
         tick();
         check($sformatf("v%0d_done2_width", i), a_done2, 0);
         a_tent = vt[i].tent;
         a_flag2 = 1;
         wait_pulse(2, 10, n);
         check($sformatf("v%0d_lat_done3", i), n, 2);
         a_flag2 = 0;
         wait_pulse(1, 20, n);
         check($sformatf("v%0d_lat_done2b", i), n, int'(vt[i].order));
         check($sformatf("v%0d_lko2", i), a_lko, vt[i].exp_l2);
         a_order = 0;
         tick(); tick();
      end

      // Default-parameter full session, with stray flag2 pulses in T50 and LOG1.
      mk = m_seed(12'h123);
      for (int j = 0; j < 16; j++) mk = m_tent(mk);
      ml1 = m_seed(mk);
      for (int j = 0; j < 16; j++) ml1 = m_logi(ml1);
      mt = m_seed(ml1);
      for (int j = 0; j < 16; j++) mt = m_tent(mt);
      ml2 = m_seed(mt);
      for (int j = 0; j < 16; j++) ml2 = m_logi(ml2);

      b_rst_n = 1;
      tick();
      mon_en = 1;
      b_key_in = 12'h123;
      b_flag1 = 1;
      tick(); tick();
      b_flag2 = 1;
      tick();
      b_flag2 = 0;
      b_flag1 = 0;
      wait_pulse(3, 40, n);
      check("b_lat_done1", n, 14);
      check("b_k", b_k, mk);
      b_key2 = mk;
      b_order = 2;
      tick(); tick();
      b_flag2 = 1;
      tick();
      b_flag2 = 0;
      wait_pulse(4, 40, n);
      check("b_lat_done2a", n, 14);
      check("b_lko1", b_lko, ml1);
      b_tent = b_lko;
      b_flag2 = 1;
      wait_pulse(5, 40, n);
      check("b_lat_done3", n, 17);
      b_flag2 = 0;
      wait_pulse(4, 40, n);
      check("b_lat_done2b", n, 16);
      check("b_lko2", b_lko, ml2);
      tick(); tick();
      mon_en = 0;
      code = 0;
      foreach (seq[j]) code = code * 10 + seq[j];
      check("b_pulse_seq", code, 1232);
      check("b_busy_cycles", busy_cnt, 64);
      check("b_busy_overlap", overlap, 0);

      // Reset while LOG1 is iterating.
      b_order = 0;
      b_key_in = 12'h321;
      b_flag1 = 1;
      wait_pulse(3, 40, n);
      check("r_lat_done1", n, 17);
      b_flag1 = 0;
      b_key2 = 12'h456;
      b_order = 1;
      tick(); tick(); tick();
      b_rst_n = 0;
      tick();
      check("r_k", b_k, 0);
      check("r_lko", b_lko, 0);
      check("r_done", {b_done1, b_done2, b_done3}, 0);
      check("r_busy", b_busy, 0);
      b_rst_n = 1;
      n = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (b_done2) n++;
      end
      check("r_no_done2", n, 0);
      b_key_in = 12'h400;
      b_flag1 = 1;
      wait_pulse(3, 40, n);
      check("r_restart_lat", n, 17);
      b_flag1 = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
